// File: rtl/seq_det_pkg.sv
// Shared constants and types for the parameterisable serial sequence detector.
// Optional build macro SEQ_DET_MATCH_CNT_EN (used by the top) enables the match counter.
package seq_det_pkg;

    localparam int SEQ_MAX_LEN = 8;
    localparam logic [7:0] SEQ_DEF_PAT = 8'b0010_1111;
    localparam int SEQ_DEF_LEN = 6;

    typedef enum logic {
        SEQ_NONOVL = 1'b0,
        SEQ_OVL    = 1'b1
    } seq_mode_e;

    function automatic int seq_len_w(input int max_len);
        return $clog2(max_len + 1);
    endfunction

endpackage

// File: rtl/seq_det_match.sv
// Combinational masked compare of the newest len bits of {history, x} against the pattern.
// Optional build macro SEQ_DET_MATCH_CNT_EN has no effect on this file.
module seq_det_match
    import seq_det_pkg::*;
#(
    parameter int MAX_LEN = SEQ_MAX_LEN,
    localparam int LEN_W = seq_len_w(MAX_LEN)
) (
    input  logic [MAX_LEN-1:0] i_word,
    input  logic [MAX_LEN-1:0] i_pat,
    input  logic [LEN_W-1:0]   i_len,
    input  logic [LEN_W-1:0]   i_v_next,
    output logic               o_match
);

    logic [MAX_LEN-1:0] w_mask;
    logic               w_len_ok;

    assign w_len_ok = (i_len != '0) && (i_len <= LEN_W'(MAX_LEN));

    always_comb begin
        w_mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            w_mask[i] = (i < int'(i_len));
        end
    end

    // Require enough accepted bits so stale or cleared history never completes a match.
    assign o_match = w_len_ok && (i_v_next >= i_len) &&
                     (((i_word ^ i_pat) & w_mask) == '0);

endmodule

// File: rtl/seq_detector_param.sv
// Moore serial sequence detector with loadable pattern/length/overlap mode and a valid qualifier.
// Build macro SEQ_DET_MATCH_CNT_EN adds a saturating match counter; otherwise match_cnt is tied to 0.
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int               MAX_LEN = SEQ_MAX_LEN,
    parameter logic [MAX_LEN-1:0] DEF_PAT = SEQ_DEF_PAT,
    parameter int               DEF_LEN = SEQ_DEF_LEN,
    parameter bit               DEF_OVL = 1'b0,
    parameter int               CNT_W   = 8,
    localparam int              LEN_W   = seq_len_w(MAX_LEN)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               x,
    input  logic               x_vld,
    input  logic               load,
    input  logic [MAX_LEN-1:0] cfg_pat,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_ovl,
    output logic               z,
    output logic [CNT_W-1:0]   match_cnt
);

    logic [MAX_LEN-1:0] r_pat;
    logic [LEN_W-1:0]   r_len;
    seq_mode_e          r_ovl;
    // The oldest history bit can never take part in a compare, so only MAX_LEN-1 bits are kept.
    logic [MAX_LEN-2:0] r_h;
    logic [LEN_W-1:0]   r_v;
    logic               r_z;

    logic [MAX_LEN-1:0] w_word;
    logic [LEN_W-1:0]   w_v_next;
    logic               w_match;

    assign w_word   = {r_h, x};
    assign w_v_next = (r_v == LEN_W'(MAX_LEN)) ? r_v : r_v + LEN_W'(1);

    seq_det_match #(
        .MAX_LEN (MAX_LEN)
    ) u_match (
        .i_word   (w_word),
        .i_pat    (r_pat),
        .i_len    (r_len),
        .i_v_next (w_v_next),
        .o_match  (w_match)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pat <= DEF_PAT;
            r_len <= LEN_W'(DEF_LEN);
            r_ovl <= seq_mode_e'(DEF_OVL);
            r_h   <= '0;
            r_v   <= '0;
            r_z   <= 1'b0;
        end else if (load) begin
            r_pat <= cfg_pat;
            r_len <= cfg_len;
            r_ovl <= seq_mode_e'(cfg_ovl);
            r_h   <= '0;
            r_v   <= '0;
            r_z   <= 1'b0;
        end else if (x_vld) begin
            r_h   <= w_word[MAX_LEN-2:0];
            r_v   <= (w_match && (r_ovl == SEQ_NONOVL)) ? '0 : w_v_next;
            r_z   <= w_match;
        end else begin
            r_z   <= 1'b0;
        end
    end

    assign z = r_z;

`ifdef SEQ_DET_MATCH_CNT_EN
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || load) begin
            r_cnt <= '0;
        end else if (x_vld && w_match && (r_cnt != '1)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign match_cnt = r_cnt;
`else
    assign match_cnt = '0;
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench for seq_detector_param: expected z per cycle is queued at drive time and checked after the edge.
module tb_seq_detector_param;

    localparam int MAX_LEN = 8;
    localparam int LEN_W   = $clog2(MAX_LEN + 1);
    localparam int CNT_W   = 8;
`ifdef SEQ_DET_MATCH_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst;
    logic               x;
    logic               x_vld;
    logic               load;
    logic [MAX_LEN-1:0] cfg_pat;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_ovl;
    logic               z;
    logic [CNT_W-1:0]   match_cnt;

    logic exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   step_no  = 0;
    string cur_tag = "reset";

    always #5 clk = ~clk;

    seq_detector_param #(
        .MAX_LEN (MAX_LEN),
        .DEF_PAT (8'b0010_1111),
        .DEF_LEN (6),
        .DEF_OVL (1'b0),
        .CNT_W   (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .x         (x),
        .x_vld     (x_vld),
        .load      (load),
        .cfg_pat   (cfg_pat),
        .cfg_len   (cfg_len),
        .cfg_ovl   (cfg_ovl),
        .z         (z),
        .match_cnt (match_cnt)
    );

    function automatic logic [CNT_W-1:0] exp_cnt(input int n);
        if (!CNT_EN) return '0;
        if (n > (2**CNT_W - 1)) return '1;
        return CNT_W'(n);
    endfunction

    // One clock: drive, queue expected z, then compare after the edge.
    task automatic step(input logic bx, input logic bv, input logic bl, input logic ez);
        logic e;
        x     = bx;
        x_vld = bv;
        load  = bl;
        exp_q.push_back(ez);
        @(posedge clk);
        #1;
        load  = 1'b0;
        x_vld = 1'b0;
        step_no++;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $error("FAIL %s empty_queue step=%0d", cur_tag, step_no);
        end else begin
            e = exp_q.pop_front();
            assert (z === e) else begin
                failures++;
                $error("FAIL %s z step=%0d got=%b exp=%b", cur_tag, step_no, z, e);
            end
        end
    endtask

    task automatic check_cnt(input logic [CNT_W-1:0] e);
        checks++;
        assert (match_cnt === e) else begin
            failures++;
            $error("FAIL %s match_cnt got=%0d exp=%0d", cur_tag, match_cnt, e);
        end
    endtask

    task automatic do_load(input logic [MAX_LEN-1:0] p, input logic [LEN_W-1:0] l, input logic o);
        cfg_pat = p;
        cfg_len = l;
        cfg_ovl = o;
        step(1'b0, 1'b0, 1'b1, 1'b0);
        check_cnt('0);
        cfg_pat = $urandom_range(0, 255);
        cfg_len = $urandom_range(0, 15);
        cfg_ovl = $urandom_range(0, 1);
    endtask

    // bits/zm: first bit sent is index n-1, last is index 0.
    task automatic send_stream(input logic [31:0] bits, input int n, input logic [31:0] zm);
        for (int k = n - 1; k >= 0; k--) begin
            step(bits[k], 1'b1, 1'b0, zm[k]);
        end
    endtask

    initial begin
        rst = 1'b1; x = 1'b0; x_vld = 1'b0; load = 1'b0;
        cfg_pat = '0; cfg_len = '0; cfg_ovl = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        assert (z === 1'b0) else begin
            failures++;
            $error("FAIL reset z got=%b exp=0", z);
        end
        check_cnt('0);

        cur_tag = "def_nonovl";
        send_stream(32'b1101_1110_0101_1110_1111, 20, 32'b0000_0010_0000_0010_0000);
        check_cnt(exp_cnt(2));

        cur_tag = "def_ovl";
        do_load(8'b0010_1111, 4'd6, 1'b1);
        send_stream(32'b1101_1110_0101_1110_1111, 20, 32'b0000_0010_0000_0010_0001);
        check_cnt(exp_cnt(3));

        cur_tag = "p11_ovl";
        do_load(8'b0000_0011, 4'd2, 1'b1);
        send_stream(32'b1111, 4, 32'b0111);
        check_cnt(exp_cnt(3));

        cur_tag = "p11_nonovl";
        do_load(8'b0000_0011, 4'd2, 1'b0);
        send_stream(32'b1111, 4, 32'b0101);
        check_cnt(exp_cnt(2));

        cur_tag = "vld_gaps";
        do_load(8'b0010_1111, 4'd6, 1'b0);
        for (int k = 5; k >= 0; k--) begin
            logic [5:0] pb;
            pb = 6'b101111;
            step(pb[k], 1'b1, 1'b0, (k == 0));
            repeat (2) step(1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0);
        end
        check_cnt(exp_cnt(1));

        cur_tag = "abandon";
        do_load(8'b0010_1111, 4'd6, 1'b0);
        send_stream(32'b10111, 5, 32'b0);
        cfg_pat = 8'b0010_1111; cfg_len = 4'd6; cfg_ovl = 1'b0;
        step(1'b1, 1'b1, 1'b1, 1'b0);
        check_cnt('0);
        send_stream(32'b1101111, 7, 32'b0000001);
        check_cnt(exp_cnt(1));

        cur_tag = "len0";
        do_load(8'($urandom_range(0, 255)), 4'd0, 1'($urandom_range(0, 1)));
        repeat (40) step(1'($urandom_range(0, 1)), 1'b1, 1'b0, 1'b0);
        check_cnt('0);

        cur_tag = "len9";
        do_load(8'($urandom_range(0, 255)), 4'd9, 1'($urandom_range(0, 1)));
        repeat (40) step(1'($urandom_range(0, 1)), 1'b1, 1'b0, 1'b0);
        check_cnt('0);

        cur_tag = "len_max";
        do_load(8'b1100_1010, 4'd8, 1'b0);
        send_stream(32'b00_1100_1010, 10, 32'b00_0000_0001);
        check_cnt(exp_cnt(1));

        cur_tag = "len1_sat";
        do_load(8'b0000_0001, 4'd1, 1'b1);
        repeat (260) step(1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        check_cnt(exp_cnt(260));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
